// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg: shared definitions for the memory access unit.
//   - access size codes
//   - access FSM state encoding
//   - size_bytes(): number of bytes moved by an access of a given size
// ---------------------------------------------------------------------------
package mem_pkg;

   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_HALF  = 2'b01;
   localparam logic [1:0] SZ_WORD  = 2'b10;
   localparam logic [1:0] SZ_DWORD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_BEAT1 = 2'b01,
      ST_BEAT2 = 2'b10,
      ST_FAULT = 2'b11
   } state_t;

   function automatic logic [3:0] size_bytes(input logic [1:0] sz);
      logic [3:0] n;
      case (sz)
         SZ_BYTE: n = 4'd1;
         SZ_HALF: n = 4'd2;
         SZ_WORD: n = 4'd4;
         default: n = 4'd8;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/mem_byte_array.sv
// ---------------------------------------------------------------------------
// mem_byte_array: DEPTH bytes of storage organised as DEPTH/4 32-bit words.
// Byte lane j of a word is the byte at word_address*4 + j and lives in bits
// [31-8j -: 8], so the lowest address is the most significant byte.
// No reset: contents survive a unit reset.
//   i_clk    write clock
//   i_waddr  word address (shared by read and write port)
//   i_be     per-lane byte write enables
//   i_wdata  write data, lane-aligned
//   o_rdata  asynchronous read of the addressed word
// ---------------------------------------------------------------------------
module mem_byte_array #(
   parameter int DEPTH = 512
) (
   input  logic                          i_clk,
   input  logic [$clog2(DEPTH/4)-1:0]    i_waddr,
   input  logic [3:0]                    i_be,
   input  logic [31:0]                   i_wdata,
   output logic [31:0]                   o_rdata
);

   logic [31:0] r_mem [DEPTH/4];

   always_ff @(posedge i_clk) begin
      for (int j = 0; j < 4; j++) begin
         if (i_be[j]) r_mem[i_waddr][31-8*j -: 8] <= i_wdata[31-8*j -: 8];
      end
   end

   assign o_rdata = r_mem[i_waddr];

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit: byte-addressed big-endian data memory with MFC handshake.
// Services byte/half/word/dword loads and stores with a programmable number
// of cycles per word beat; misaligned or out-of-range requests produce a
// one-cycle trap pulse instead of an access.
//   i_clk, i_clr_n            clock / async active-low reset
//   i_req, i_we, i_size,      request (sampled only while idle)
//   i_sign, i_addr
//   i_wdata, i_wdata2         store data (first / second word)
//   o_rdata, o_rdata2         load results, held until the next load
//   o_busy                    access or fault in progress
//   o_mfc                     memory function complete pulse
//   o_misalign, o_oor         trap pulses
// ---------------------------------------------------------------------------
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W  = 9,
   parameter int DEPTH   = 512,
   parameter int LATENCY = 2
) (
   input  logic              i_clk,
   input  logic              i_clr_n,
   input  logic              i_req,
   input  logic              i_we,
   input  logic [1:0]        i_size,
   input  logic              i_sign,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_wdata,
   input  logic [31:0]       i_wdata2,
   output logic [31:0]       o_rdata,
   output logic [31:0]       o_rdata2,
   output logic              o_busy,
   output logic              o_mfc,
   output logic              o_misalign,
   output logic              o_oor
);

   localparam int              WA_W     = $clog2(DEPTH/4);
   localparam int              CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0]   CNT_INIT = CW'(LATENCY - 1);
   // two spare bits so addr+7 and DEPTH (up to 2**ADDR_W) never overflow
   localparam int              EW       = ADDR_W + 2;

   state_t              r_state, w_next;
   logic [CW-1:0]       r_cnt;
   logic                r_we, r_sign;
   logic [1:0]          r_size;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata, r_wdata2;
   logic [31:0]         r_rdata, r_rdata2;
   logic                r_mfc, r_misalign, r_oor;

   logic                w_accept, w_misal, w_oor, w_beat, w_fire, w_last;
   logic [EW-1:0]       w_end;
   logic [ADDR_W-1:0]   w_beat_addr;
   logic [3:0]          w_lanes, w_be;
   logic [31:0]         w_wd, w_rd, w_sh, w_ld;
   logic                w_unused;

   // ---- request checks --------------------------------------------------
   assign w_accept = (r_state == ST_IDLE) && i_req;

   always_comb begin
      w_misal = 1'b0;
      case (i_size)
         SZ_HALF:  w_misal = i_addr[0];
         SZ_WORD:  w_misal = |i_addr[1:0];
         SZ_DWORD: w_misal = |i_addr[2:0];
         default:  w_misal = 1'b0;
      endcase
   end

   assign w_end = EW'(i_addr) + EW'(size_bytes(i_size)) - EW'(1);
   assign w_oor = (w_end >= EW'(DEPTH));

   // ---- beat timing -----------------------------------------------------
   assign w_beat = (r_state == ST_BEAT1) || (r_state == ST_BEAT2);
   assign w_fire = w_beat && (r_cnt == '0);
   // the beat that completes the whole access (raises MFC next cycle)
   assign w_last = w_fire && ((r_state == ST_BEAT2) || (r_size != SZ_DWORD));

   // ---- FSM ---------------------------------------------------------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (i_req)  w_next = (w_misal || w_oor) ? ST_FAULT : ST_BEAT1;
         ST_BEAT1: if (w_fire) w_next = (r_size == SZ_DWORD) ? ST_BEAT2 : ST_IDLE;
         ST_BEAT2: if (w_fire) w_next = ST_IDLE;
         ST_FAULT: w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   // ---- lane steering -----------------------------------------------------
   assign w_beat_addr = (r_state == ST_BEAT2) ? r_addr + ADDR_W'(4) : r_addr;
   assign w_unused    = &{1'b0, w_beat_addr};

   always_comb begin
      w_lanes = 4'b1111;
      w_wd    = (r_state == ST_BEAT2) ? r_wdata2 : r_wdata;
      case (r_size)
         // replicate the data; the byte enables pick the lane(s) that land
         SZ_BYTE: begin
            w_lanes = 4'b0001 << r_addr[1:0];
            w_wd    = {4{r_wdata[7:0]}};
         end
         SZ_HALF: begin
            w_lanes = 4'b0011 << r_addr[1:0];
            w_wd    = {2{r_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign w_be = (w_fire && r_we) ? w_lanes : 4'b0000;

   mem_byte_array #(.DEPTH(DEPTH)) u_array (
      .i_clk   (i_clk),
      .i_waddr (w_beat_addr[WA_W+1:2]),
      .i_be    (w_be),
      .i_wdata (w_wd),
      .o_rdata (w_rd)
   );

   // shift the addressed byte/half up to the top of the word, then extend
   assign w_sh = w_rd << {r_addr[1:0], 3'b000};

   always_comb begin
      w_ld = w_rd;
      case (r_size)
         SZ_BYTE: w_ld = {{24{r_sign & w_sh[31]}}, w_sh[31:24]};
         SZ_HALF: w_ld = {{16{r_sign & w_sh[31]}}, w_sh[31:16]};
         default: ;
      endcase
   end

   // ---- datapath / status registers -----------------------------------
   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         r_cnt      <= '0;
         r_we       <= 1'b0;
         r_sign     <= 1'b0;
         r_size     <= SZ_BYTE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_wdata2   <= '0;
         r_rdata    <= '0;
         r_rdata2   <= '0;
         r_mfc      <= 1'b0;
         r_misalign <= 1'b0;
         r_oor      <= 1'b0;
      end else begin
         r_mfc      <= w_last;
         r_misalign <= w_accept && w_misal;
         r_oor      <= w_accept && !w_misal && w_oor;
         if (w_accept) begin
            r_we     <= i_we;
            r_sign   <= i_sign;
            r_size   <= i_size;
            r_addr   <= i_addr;
            r_wdata  <= i_wdata;
            r_wdata2 <= i_wdata2;
            r_cnt    <= CNT_INIT;
         end else if (w_beat) begin
            r_cnt <= (r_cnt == '0) ? CNT_INIT : r_cnt - CW'(1);
         end
         if (w_fire && !r_we) begin
            if (r_state == ST_BEAT2) r_rdata2 <= w_rd;
            else                     r_rdata  <= w_ld;
         end
      end
   end

   assign o_rdata    = r_rdata;
   assign o_rdata2   = r_rdata2;
   assign o_busy     = (r_state != ST_IDLE);
   assign o_mfc      = r_mfc;
   assign o_misalign = r_misalign;
   assign o_oor      = r_oor;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// Bench for mem_access_unit (ADDR_W=10 so out-of-range addresses exist).
// A timeline model (accept edge + fixed latency, byte-array memory) predicts
// every output; a negedge process compares against it each cycle. Directed
// accesses pin the model with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

   localparam int AW    = 10;
   localparam int DEPTH = 512;
   localparam int L     = 2;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          req = 1'b0, we = 1'b0, sign = 1'b0;
   logic [1:0]    size = 2'b00;
   logic [AW-1:0] addr = '0;
   logic [31:0]   wdata = '0, wdata2 = '0;
   logic [31:0]   rdata, rdata2;
   logic          busy, mfc, mis, oor;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(L)) dut (
      .i_clk(clk), .i_clr_n(rst_n), .i_req(req), .i_we(we), .i_size(size),
      .i_sign(sign), .i_addr(addr), .i_wdata(wdata), .i_wdata2(wdata2),
      .o_rdata(rdata), .o_rdata2(rdata2), .o_busy(busy), .o_mfc(mfc),
      .o_misalign(mis), .o_oor(oor)
   );

   int total = 0, bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---- behavioural model -------------------------------------------------
   logic [7:0]  mm [DEPTH];
   int          e = 0, busy_end = -1, beat1_at = -1, nb_m;
   bit          pend = 0, m_we, m_sg, bm, bo;
   logic [1:0]  m_sz;
   int          m_a;
   logic [31:0] m_d, m_d2, v;
   logic [31:0] x_rd = '0, x_rd2 = '0;
   bit          x_busy = 0, x_mfc = 0, x_mis = 0, x_oor = 0;

   function automatic logic [31:0] rd_bytes(input int a, input int n);
      logic [31:0] r = '0;
      for (int i = 0; i < n; i++) r = (r << 8) | 32'(mm[a+i]);
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend = 0; busy_end = -1;
         x_rd = '0; x_rd2 = '0; x_busy = 0; x_mfc = 0; x_mis = 0; x_oor = 0;
      end else begin
         e++;
         x_mfc = 0; x_mis = 0; x_oor = 0;
         // first word of a dword lands after one latency period
         if (pend && m_sz == 2'b11 && e == beat1_at) begin
            if (m_we) for (int i = 0; i < 4; i++) mm[m_a+i] = m_d[8*(3-i) +: 8];
            else x_rd = rd_bytes(m_a, 4);
         end
         if (pend && e == busy_end) begin
            pend = 0; x_mfc = 1;
            if (m_sz == 2'b11) begin
               if (m_we) for (int i = 0; i < 4; i++) mm[m_a+4+i] = m_d2[8*(3-i) +: 8];
               else x_rd2 = rd_bytes(m_a + 4, 4);
            end else begin
               nb_m = 1 << m_sz;
               if (m_we) for (int i = 0; i < nb_m; i++) mm[m_a+i] = m_d[8*(nb_m-1-i) +: 8];
               else begin
                  v = rd_bytes(m_a, nb_m);
                  if (m_sg && nb_m == 1 && v[7])  v = v | 32'hFFFF_FF00;
                  if (m_sg && nb_m == 2 && v[15]) v = v | 32'hFFFF_0000;
                  x_rd = v;
               end
            end
         end
         if (e > busy_end && req) begin
            nb_m = 1 << size;
            bm = (int'(addr) % nb_m) != 0;
            bo = (int'(addr) + nb_m) > DEPTH;
            if (bm || bo) begin
               x_mis = bm; x_oor = !bm; busy_end = e + 1;
            end else begin
               pend = 1; m_we = we; m_sz = size; m_sg = sign; m_a = int'(addr);
               m_d = wdata; m_d2 = wdata2;
               beat1_at = e + L;
               busy_end = e + ((size == 2'b11) ? 2*L : L);
            end
         end
         x_busy = (e < busy_end);
      end
   end

   // ---- per-cycle compare -----------------------------------------------
   always @(negedge clk) begin
      chk("busy",     {31'd0, busy}, {31'd0, x_busy});
      chk("mfc",      {31'd0, mfc},  {31'd0, x_mfc});
      chk("misalign", {31'd0, mis},  {31'd0, x_mis});
      chk("oor",      {31'd0, oor},  {31'd0, x_oor});
      chk("rdata",    rdata,  x_rd);
      chk("rdata2",   rdata2, x_rd2);
   end

   // One request; lat = number of negedges after the request negedge until
   // MFC or a trap shows (-1 on timeout). Accept is the next posedge, so an
   // N-cycle access shows up at lat = N+1 and a trap at lat = 1.
   task automatic acc(input bit w, input logic [1:0] sz, input bit sg, input logic [AW-1:0] a,
                      input logic [31:0] d, input logic [31:0] d2, output int lat);
      @(negedge clk);
      req = 1; we = w; size = sz; sign = sg; addr = a; wdata = d; wdata2 = d2;
      lat = -1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         req = 0;
         if (mfc || mis || oor) begin lat = k; break; end
      end
   endtask

   initial begin
      int lat, r, nb, tmp;
      logic [15:0] mask;

      repeat (2) @(negedge clk);
      #2 rst_n = 1;

      // fill the whole memory so every later load has a defined answer
      for (int i = 0; i < DEPTH/4; i++) begin
         acc(1, 2'b10, 0, AW'(i*4), $urandom, 32'h0, lat);
         chk("fill_lat", lat, L + 1);
      end

      acc(1, 2'b10, 0, 10'h010, 32'hDEADBEEF, 32'h0, lat);  chk("st_w_lat", lat, L + 1);
      acc(0, 2'b10, 0, 10'h010, 32'h0, 32'h0, lat);         chk("ld_w_lat", lat, L + 1);
      chk("ld_w", rdata, 32'hDEADBEEF);
      chk("ld_w_mdl", x_rd, 32'hDEADBEEF);
      acc(0, 2'b00, 1, 10'h010, 32'h0, 32'h0, lat);         chk("ld_b_s", rdata, 32'hFFFFFFDE);
      acc(0, 2'b00, 0, 10'h010, 32'h0, 32'h0, lat);         chk("ld_b_z", rdata, 32'h000000DE);
      acc(0, 2'b01, 1, 10'h012, 32'h0, 32'h0, lat);         chk("ld_h_s", rdata, 32'hFFFFBEEF);
      acc(1, 2'b00, 0, 10'h011, 32'h00000077, 32'h0, lat);  // byte store into lane 1
      acc(0, 2'b10, 0, 10'h010, 32'h0, 32'h0, lat);         chk("st_b_lane", rdata, 32'hDE77BEEF);

      acc(1, 2'b11, 0, 10'h020, 32'h11111111, 32'h22222222, lat); chk("st_d_lat", lat, 2*L + 1);
      acc(0, 2'b11, 0, 10'h020, 32'h0, 32'h0, lat);         chk("ld_d_lat", lat, 2*L + 1);
      chk("ld_d0", rdata, 32'h11111111);
      chk("ld_d1", rdata2, 32'h22222222);

      acc(0, 2'b10, 0, 10'h013, 32'h0, 32'h0, lat);
      chk("mis_lat", lat, 1); chk("mis_pulse", {31'd0, mis}, 32'd1);
      chk("mis_nomfc", {31'd0, mfc}, 32'd0); chk("mis_keep", rdata, 32'h11111111);
      acc(0, 2'b10, 0, 10'h1FE, 32'h0, 32'h0, lat);
      chk("mis2_pulse", {31'd0, mis}, 32'd1); chk("mis2_nooor", {31'd0, oor}, 32'd0);
      acc(0, 2'b10, 0, 10'h200, 32'h0, 32'h0, lat);
      chk("oor_lat", lat, 1); chk("oor_pulse", {31'd0, oor}, 32'd1);
      chk("oor_busy", {31'd0, busy}, 32'd1);
      acc(0, 2'b10, 0, 10'h010, 32'h0, 32'h0, lat);         chk("after_trap", rdata, 32'hDE77BEEF);

      // reset in the middle of a dword store: neither word may change
      acc(1, 2'b10, 0, 10'h040, 32'h01234567, 32'h0, lat);
      acc(1, 2'b10, 0, 10'h044, 32'h89ABCDEF, 32'h0, lat);
      @(negedge clk);
      req = 1; we = 1; size = 2'b11; addr = 10'h040; wdata = 32'hCAFEF00D; wdata2 = 32'h0BADC0DE;
      @(negedge clk);
      req = 0;
      #2 rst_n = 0;
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_rdata2", rdata2, 32'h0);
      @(negedge clk);
      #2 rst_n = 1;
      acc(0, 2'b10, 0, 10'h040, 32'h0, 32'h0, lat);         chk("rst_old0", rdata, 32'h01234567);
      acc(0, 2'b10, 0, 10'h044, 32'h0, 32'h0, lat);         chk("rst_old1", rdata, 32'h89ABCDEF);

      // req held high: accepted again in the MFC cycle, ignored while busy
      @(negedge clk);
      req = 1; we = 0; size = 2'b10; sign = 0; addr = 10'h010;
      mask = '0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 6) req = 0;
         mask[k] = mfc;
      end
      chk("held_mfc", {16'd0, mask}, 32'h0000_0048);

      // randomized traffic
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk);
         req  = ($urandom_range(0, 2) != 0);
         we   = 1'($urandom_range(0, 1));
         size = 2'($urandom_range(0, 3));
         sign = 1'($urandom_range(0, 1));
         nb   = 1 << size;
         r    = int'($urandom_range(0, 9));
         if (r < 7) begin
            tmp  = int'($urandom_range(0, DEPTH - 1)) & ~(nb - 1);
            addr = AW'(tmp);
         end else if (r < 9) addr = AW'($urandom_range(0, DEPTH - 1));
         else                addr = AW'($urandom_range(DEPTH - 16, 1023));
         wdata  = $urandom;
         wdata2 = $urandom;
      end
      @(negedge clk);
      req = 0;
      repeat (12) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
